// File: rtl/dot_pkg.sv
// Shared helpers for the pipelined dot-product block: sum-width derivation
// and the output saturation helper used when DOT_OUT_SAT_EN is defined.
package dot_pkg;

   // Working width of the saturation helper; any SUM_W / OUT_W pair fits.
   localparam int SAT_W = 64;

   // Full-precision sum width: the product needs 2*data_w bits, the n-term
   // accumulation needs $clog2(n) more, and one extra bit carries the sign.
   function automatic int dot_sum_w(input int n, input int data_w);
      return 2 * data_w + $clog2(n) + 1;
   endfunction

   // Clamp a sign- or zero-extended value to the range of an out_w-bit
   // result. The caller keeps the low out_w bits of the return value.
   function automatic logic [SAT_W-1:0] sat_trunc(input logic [SAT_W-1:0] val,
                                                  input int               out_w,
                                                  input logic             is_signed);
      logic signed [SAT_W-1:0] sval;
      logic signed [SAT_W-1:0] smax;
      logic signed [SAT_W-1:0] smin;
      logic [SAT_W-1:0]        umax;
      logic [SAT_W-1:0]        res;
      sval = signed'(val);
      smax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      smin = -(64'sd1 <<< (out_w - 1));
      umax = (64'd1 << out_w) - 64'd1;
      res  = val;
      if (is_signed) begin
         if (sval > smax) begin
            res = smax;
         end else if (sval < smin) begin
            res = smin;
         end
      end else if (val > umax) begin
         res = umax;
      end
      return res;
   endfunction

endpackage

// File: rtl/dot_mac_stage.sv
// One accumulate stage of the dot-product pipeline. The element operands
// enter at pipeline acceptance and ride a DEPTH-deep delay line so they meet
// their beat's partial sum here. The beat's signed flag travels with valid.
module dot_mac_stage #(
   parameter int DATA_W = 3,
   parameter int SUM_W  = 9,
   parameter int DEPTH  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              prev_valid,
   input  logic              prev_signed,
   input  logic [SUM_W-1:0]  prev_sum,
   output logic              stage_valid,
   output logic              stage_signed,
   output logic [SUM_W-1:0]  stage_sum
);

   logic [DATA_W-1:0] a_al;
   logic [DATA_W-1:0] b_al;

   generate
      if (DEPTH == 0) begin : g_nodly
         assign a_al = op_a;
         assign b_al = op_b;
      end else begin : g_dly
         logic [DATA_W-1:0] dly_a [DEPTH];
         logic [DATA_W-1:0] dly_b [DEPTH];

         // Operand delay line, shifting only when the pipeline advances.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  dly_a[i] <= '0;
                  dly_b[i] <= '0;
               end
            end else if (en) begin
               dly_a[0] <= op_a;
               dly_b[0] <= op_b;
               for (int i = 1; i < DEPTH; i++) begin
                  dly_a[i] <= dly_a[i-1];
                  dly_b[i] <= dly_b[i-1];
               end
            end
         end

         assign a_al = dly_a[DEPTH-1];
         assign b_al = dly_b[DEPTH-1];
      end
   endgenerate

   logic signed [DATA_W:0]  a_x;
   logic signed [DATA_W:0]  b_x;
   logic signed [SUM_W-1:0] prod;
   logic [SUM_W-1:0]        sum_nxt;

   // Extend operands by one bit (sign or zero) so a single signed multiply
   // covers both modes, then widen to the full sum precision.
   always_comb begin
      a_x     = {prev_signed & a_al[DATA_W-1], a_al};
      b_x     = {prev_signed & b_al[DATA_W-1], b_al};
      prod    = SUM_W'(a_x) * SUM_W'(b_x);
      sum_nxt = prev_sum + $unsigned(prod);
   end

   // Stage register: partial sum plus the beat's valid/signed tags.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid  <= 1'b0;
         stage_signed <= 1'b0;
         stage_sum    <= '0;
      end else if (en) begin
         stage_valid  <= prev_valid;
         stage_signed <= prev_signed;
         stage_sum    <= sum_nxt;
      end
   end

endmodule

// File: rtl/pipelined_dot_product.sv
// Pipelined inner product of two N-element vectors, one result per cycle.
// N accumulate stages feed a width-reducing output register (latency N).
// The whole pipeline stalls together while a result waits on out_ready.
// Optional macro DOT_OUT_SAT_EN: saturate out_data to OUT_W instead of
// wrapping when OUT_W < SUM_W.
module pipelined_dot_product
   import dot_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 3,
   parameter int OUT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_signed,
   input  logic [N*DATA_W-1:0] in_a,
   input  logic [N*DATA_W-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_data
);

   localparam int SUM_W = dot_sum_w(N, DATA_W);

   logic             advance;
   logic             st_valid  [N];
   logic             st_signed [N];
   logic [SUM_W-1:0] st_sum    [N];
   logic [OUT_W-1:0] out_nxt;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   generate
      for (genvar k = 0; k < N; k++) begin : g_stage
         if (k == 0) begin : g_first
            dot_mac_stage #(
               .DATA_W (DATA_W),
               .SUM_W  (SUM_W),
               .DEPTH  (0)
            ) u_stage (
               .clk          (clk),
               .rst          (rst),
               .en           (advance),
               .op_a         (in_a[0 +: DATA_W]),
               .op_b         (in_b[0 +: DATA_W]),
               .prev_valid   (in_valid),
               .prev_signed  (in_signed),
               .prev_sum     ({SUM_W{1'b0}}),
               .stage_valid  (st_valid[0]),
               .stage_signed (st_signed[0]),
               .stage_sum    (st_sum[0])
            );
         end else begin : g_next
            dot_mac_stage #(
               .DATA_W (DATA_W),
               .SUM_W  (SUM_W),
               .DEPTH  (k)
            ) u_stage (
               .clk          (clk),
               .rst          (rst),
               .en           (advance),
               .op_a         (in_a[k*DATA_W +: DATA_W]),
               .op_b         (in_b[k*DATA_W +: DATA_W]),
               .prev_valid   (st_valid[k-1]),
               .prev_signed  (st_signed[k-1]),
               .prev_sum     (st_sum[k-1]),
               .stage_valid  (st_valid[k]),
               .stage_signed (st_signed[k]),
               .stage_sum    (st_sum[k])
            );
         end
      end

      if (OUT_W >= SUM_W) begin : g_ext
         // Output is wide enough: extend per the beat's signedness.
         always_comb begin
            if (st_signed[N-1]) begin
               out_nxt = OUT_W'($signed(st_sum[N-1]));
            end else begin
               out_nxt = OUT_W'(st_sum[N-1]);
            end
         end
      end else begin : g_narrow
`ifdef DOT_OUT_SAT_EN
         logic [SAT_W-1:0] sum_ext;
         logic [SAT_W-1:0] sat_val;
         logic             unused_sat;

         // Clamp the full-precision sum into the OUT_W range.
         always_comb begin
            sum_ext = st_signed[N-1] ? SAT_W'($signed(st_sum[N-1]))
                                     : SAT_W'(st_sum[N-1]);
            sat_val = sat_trunc(sum_ext, OUT_W, st_signed[N-1]);
            out_nxt = sat_val[OUT_W-1:0];
         end

         assign unused_sat = ^sat_val[SAT_W-1:OUT_W];
`else
         logic unused_hi;

         // Wrap: keep only the low OUT_W bits of the sum.
         assign out_nxt   = st_sum[N-1][OUT_W-1:0];
         assign unused_hi = ^{st_sum[N-1][SUM_W-1:OUT_W], st_signed[N-1]};
`endif
      end
   endgenerate

   // Output register; holds result and valid while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (advance) begin
         out_valid <= st_valid[N-1];
         out_data  <= out_nxt;
      end
   end

endmodule

// File: tb/tb_pipelined_dot_product.sv
// Directed bench for pipelined_dot_product: reset, latency, signed/unsigned
// beats, stalled streaming, wrap/saturation widths and mid-flight reset.
module tb_pipelined_dot_product;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // Main instance: N=3, DATA_W=3, OUT_W=8
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_signed = 1'b0;
   logic [8:0] in_a = '0;
   logic [8:0] in_b = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;

   // Wide-operand instance: N=3, DATA_W=4, OUT_W=8
   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic        w_in_signed = 1'b0;
   logic [11:0] w_in_a = '0;
   logic [11:0] w_in_b = '0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b1;
   logic [7:0]  w_out_data;

   // Narrow-output instance: N=3, DATA_W=4, OUT_W=6
   logic        n_in_valid = 1'b0;
   logic        n_in_ready;
   logic        n_in_signed = 1'b0;
   logic [11:0] n_in_a = '0;
   logic [11:0] n_in_b = '0;
   logic        n_out_valid;
   logic        n_out_ready = 1'b1;
   logic [5:0]  n_out_data;

   int checks   = 0;
   int failures = 0;

   logic [8:0] va [16];
   logic [8:0] vb [16];
   logic       vs [16];
   logic [7:0] ve [16];
   int         nvec;

`ifdef DOT_OUT_SAT_EN
   localparam logic [7:0] EXP_W675  = 8'd255;
   localparam logic [5:0] EXP_N_NEG = 6'h20;
   localparam logic [5:0] EXP_N_POS = 6'h1F;
`else
   localparam logic [7:0] EXP_W675  = 8'd163;
   localparam logic [5:0] EXP_N_NEG = 6'h18;
   localparam logic [5:0] EXP_N_POS = 6'h00;
`endif

   pipelined_dot_product #(.N(3), .DATA_W(3), .OUT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   pipelined_dot_product #(.N(3), .DATA_W(4), .OUT_W(8)) dut_w (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .in_signed (w_in_signed),
      .in_a      (w_in_a),
      .in_b      (w_in_b),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .out_data  (w_out_data)
   );

   pipelined_dot_product #(.N(3), .DATA_W(4), .OUT_W(6)) dut_n (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (n_in_valid),
      .in_ready  (n_in_ready),
      .in_signed (n_in_signed),
      .in_a      (n_in_a),
      .in_b      (n_in_b),
      .out_valid (n_out_valid),
      .out_ready (n_out_ready),
      .out_data  (n_out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference dot product for the 3x3-bit instance, reduced to 8 bits.
   function automatic logic [7:0] model(input logic [8:0] a, input logic [8:0] b, input logic s);
      int sum;
      sum = 0;
      for (int k = 0; k < 3; k++) begin
         int ea;
         int eb;
         ea = s ? int'($signed(a[k*3 +: 3])) : int'(a[k*3 +: 3]);
         eb = s ? int'($signed(b[k*3 +: 3])) : int'(b[k*3 +: 3]);
         sum += ea * eb;
      end
`ifdef DOT_OUT_SAT_EN
      if (s) begin
         if (sum > 127) sum = 127;
         if (sum < -128) sum = -128;
      end else if (sum > 255) begin
         sum = 255;
      end
`endif
      return sum[7:0];
   endfunction

   // Drive the vector table with in_valid held while beats remain; out_ready
   // is 1 on every ready_period-th cycle. Checks order, hold and in_ready.
   task automatic run_stream(input int ready_period);
      int         sent = 0;
      int         recv = 0;
      int         cyc  = 0;
      logic       hold = 1'b0;
      logic [7:0] hold_d = '0;
      while (recv < nvec && cyc < 300) begin
         @(negedge clk);
         out_ready = ((cyc % ready_period) == 0);
         in_valid  = (sent < nvec);
         if (sent < nvec) begin
            in_a      = va[sent];
            in_b      = vb[sent];
            in_signed = vs[sent];
         end
         #1;
         check("in_ready_eq_advance", in_ready, !out_valid || out_ready);
         if (hold) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_data", out_data, hold_d);
         end
         if (out_valid && out_ready) begin
            check($sformatf("stream_result_%0d", recv), out_data, ve[recv]);
            recv++;
         end
         hold   = out_valid && !out_ready;
         hold_d = out_data;
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      check("stream_all_received", recv, nvec);
   endtask

   task automatic drain_idle(input string tag, input int cycles);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         #1;
         check(tag, out_valid, 0);
      end
   endtask

   initial begin
      int lat;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_w_out_valid", w_out_valid, 0);
      check("reset_n_out_valid", n_out_valid, 0);
      @(negedge clk);
      rst = 1'b0;

      // Unsigned max operands, latency from accept
      @(negedge clk);
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_a      = {3{3'd7}};
      in_b      = {3{3'd7}};
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency_cycles", lat, 3);
      check("unsigned_7x7_sum", out_data, 8'd147);
      drain_idle("no_dup_after_single", 3);

      // Signed and mixed beats back-to-back
      va[0] = {3'd3, 3'd2, 3'd7}; vb[0] = {3'd2, 3'd7, 3'd3}; vs[0] = 1'b1; ve[0] = 8'd1;
      va[1] = {3{3'd4}};          vb[1] = {3{3'd3}};          vs[1] = 1'b1; ve[1] = 8'hDC;
      va[2] = {3'd5, 3'd0, 3'd7}; vb[2] = {3'd3, 3'd7, 3'd1}; vs[2] = 1'b0; ve[2] = 8'd22;
      va[3] = {3{3'd4}};          vb[3] = {3{3'd3}};          vs[3] = 1'b0; ve[3] = 8'd36;
      va[4] = {3{3'd4}};          vb[4] = {3{3'd4}};          vs[4] = 1'b1; ve[4] = 8'd48;
      nvec = 5;
      run_stream(1);
      drain_idle("no_dup_after_mixed", 4);

      // Ten random beats with a stalling consumer
      for (int i = 0; i < 10; i++) begin
         va[i] = 9'($urandom);
         vb[i] = 9'($urandom);
         vs[i] = 1'($urandom_range(0, 1));
         ve[i] = model(va[i], vb[i], vs[i]);
      end
      nvec = 10;
      run_stream(3);
      drain_idle("no_dup_after_stream", 4);

      // Wide operands, 8-bit output: 675 wraps or saturates
      @(negedge clk);
      w_in_valid  = 1'b1;
      w_in_signed = 1'b0;
      w_in_a      = {3{4'd15}};
      w_in_b      = {3{4'd15}};
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      lat = 0;
      while (w_out_valid !== 1'b1 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("w_latency", lat, 3);
      check("w_unsigned_675", w_out_data, EXP_W675);

      // Narrow signed output: -168 and 192
      @(negedge clk);
      n_in_valid  = 1'b1;
      n_in_signed = 1'b1;
      n_in_a      = {3{4'h8}};
      n_in_b      = {3{4'h7}};
      @(negedge clk);
      n_in_b      = {3{4'h8}};
      @(negedge clk);
      n_in_valid  = 1'b0;
      lat = 0;
      while (n_out_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check("n_first_arrives", n_out_valid, 1);
      check("n_signed_neg168", n_out_data, EXP_N_NEG);
      @(negedge clk);
      #1;
      check("n_second_valid", n_out_valid, 1);
      check("n_signed_pos192", n_out_data, EXP_N_POS);

      // Reset with two beats in flight and the output stalled
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_a      = {3{3'd1}};
      in_b      = {3{3'd1}};
      @(negedge clk);
      in_a      = {3{3'd2}};
      @(negedge clk);
      in_valid  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("pre_reset_stalled_valid", out_valid, 1);
      check("pre_reset_stalled_data", out_data, 8'd3);
      check("pre_reset_in_ready", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midflight_reset_out_valid", out_valid, 0);
      check("midflight_reset_out_data", out_data, 0);
      check("midflight_reset_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      drain_idle("no_stale_after_reset", 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
